faddsub_pipe: RTL

Parametrised, fully pipelined IEEE-754 single-precision adder/subtractor with per-operation mode select, valid/ready backpressure, a sideband tag and exception flags. It is the successor to the fixed-function 3-stage subtractor in the FPU. It issues one operation per cycle into the FPU result path. Unlike its predecessor it stalls cleanly under backpressure, flushes denormals, and handles zero, Inf and NaN inputs.

---
 rtl/fpu_pkg.sv | 23 ++
 rtl/fp_lzc.sv | 15 +
 rtl/faddsub_pipe.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// Shared binary32 types, constants and operand classification for the FPU datapaths.
package fpu_pkg;

  typedef struct packed {
    logic       sign;
    logic [7:0] exp;
    logic [22:0] man;
  } fp32_t;

  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;
  localparam logic [31:0] FP_PINF = 32'h7F80_0000;
  localparam logic [7:0]  EXP_MAX = 8'hFF;

  typedef enum logic [1:0] {ZERO, NORM, INF, NAN} fp_class_t;

  // Exponent 0 is always ZERO: denormal mantissas are ignored.
  function automatic fp_class_t classify(input fp32_t v);
    if (v.exp == '0) return ZERO;
    if (v.exp == EXP_MAX) return (v.man == '0) ? INF : NAN;
    return NORM;
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter over a 27-bit extended mantissa.
module fp_lzc (
  input  logic [26:0] value,
  output logic [4:0]  count
);

  // Ascending scan: the highest set bit is the last to write the count.
  always_comb begin
    count = 5'd27;
    for (int unsigned i = 0; i < 27; i++) begin
      if (value[i]) count = 5'(26 - i);
    end
  end

endmodule

// File: rtl/faddsub_pipe.sv
// Three-stage pipelined binary32 add/subtract with valid/ready flow control,
// sideband tag, flush-to-zero and Inf/NaN handling.
module faddsub_pipe
  import fpu_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [31:0]      x1,
  input  logic [31:0]      x2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      y,
  output logic [TAG_W-1:0] out_tag,
  output logic             ovf,
  output logic             nan
);

  typedef enum logic [1:0] {SP_NONE, SP_NAN, SP_INF} special_t;

  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // ---------------- S1: unpack, classify, compare, align, add
  fp32_t      a, b;
  fp_class_t  ca, cb;
  logic       sb, swap, big_s, small_s;
  logic [7:0] big_e, small_e, diff_e;
  logic [23:0] big_m, small_m;
  logic [4:0]  sh;
  logic [57:0] wide;
  logic [26:0] big_x, aligned;
  logic [27:0] sum;
  special_t   sp_n;
  logic       sp_sign_n;

  always_comb begin
    a  = x1;
    b  = x2;
    sb = b.sign ^ op;
    ca = classify(a);
    cb = classify(b);
    swap    = ((b.exp == '0) ? 31'd0 : b[30:0]) > ((a.exp == '0) ? 31'd0 : a[30:0]);
    big_s   = swap ? sb : a.sign;
    small_s = swap ? a.sign : sb;
    big_e   = swap ? b.exp : a.exp;
    small_e = swap ? a.exp : b.exp;
    big_m   = (big_e == '0) ? '0 : {1'b1, swap ? b.man : a.man};
    small_m = (small_e == '0) ? '0 : {1'b1, swap ? a.man : b.man};
    diff_e  = big_e - small_e;
    sh      = (diff_e > 8'd31) ? 5'd31 : diff_e[4:0];
    // Shift into a wide window so every bit lost below S folds into sticky.
    wide    = {small_m, 34'd0} >> sh;
    aligned = {wide[57:32], wide[31] | (|wide[30:0])};
    big_x   = {big_m, 3'b000};
    sum     = (big_s ^ small_s) ? {1'b0, big_x} - {1'b0, aligned}
                                : {1'b0, big_x} + {1'b0, aligned};
    sp_n      = SP_NONE;
    sp_sign_n = 1'b0;
    if (ca == NAN || cb == NAN || (ca == INF && cb == INF && a.sign != sb)) begin
      sp_n = SP_NAN;
    end else if (ca == INF) begin
      sp_n      = SP_INF;
      sp_sign_n = a.sign;
    end else if (cb == INF) begin
      sp_n      = SP_INF;
      sp_sign_n = sb;
    end
  end

  logic             v1, v2;
  logic [27:0]      s1_sum;
  logic [7:0]       s1_exp;
  logic             s1_sign, s1_zsign, s1_sp_sign;
  special_t         s1_sp;
  logic [TAG_W-1:0] s1_tag;

  // ---------------- S2: carry adjust, leading-zero count, normalise
  logic [4:0]         lz;
  logic               carry;
  logic [26:0]        norm_m;
  logic signed [9:0]  norm_e;

  fp_lzc u_lzc (
    .value (s1_sum[26:0]),
    .count (lz)
  );

  always_comb begin
    carry  = s1_sum[27];
    norm_m = carry ? {s1_sum[27:2], s1_sum[1] | s1_sum[0]} : (s1_sum[26:0] << lz);
    norm_e = carry ? ({2'b00, s1_exp} + 10'd1) : ({2'b00, s1_exp} - {5'd0, lz});
  end

  logic [26:0]        s2_man;
  logic signed [9:0]  s2_exp;
  logic               s2_zero, s2_sign, s2_zsign, s2_sp_sign;
  special_t           s2_sp;
  logic [TAG_W-1:0]   s2_tag;

  // ---------------- S3: round to nearest even, pack, special-case mux
  logic               rnd_up;
  logic [24:0]        rnd_m;
  logic signed [9:0]  rnd_e;
  logic [22:0]        frac;
  logic [31:0]        y_n;
  logic               ovf_n, nan_n;

  always_comb begin
    rnd_up = s2_man[2] & (s2_man[1] | s2_man[0] | s2_man[3]);
    rnd_m  = {1'b0, s2_man[26:3]} + 25'(rnd_up);
    rnd_e  = rnd_m[24] ? s2_exp + 10'sd1 : s2_exp;
    frac   = rnd_m[24] ? rnd_m[23:1] : rnd_m[22:0];
    y_n    = {s2_sign, rnd_e[7:0], frac};
    ovf_n  = 1'b0;
    nan_n  = 1'b0;
    if (s2_sp == SP_NAN) begin
      y_n   = FP_QNAN;
      nan_n = 1'b1;
    end else if (s2_sp == SP_INF) begin
      y_n = FP_PINF | {s2_sp_sign, 31'd0};
    end else if (s2_zero) begin
      y_n = {s2_zsign, 31'd0};
    end else if (s2_exp <= 10'sd0) begin
      y_n = {s2_sign, 31'd0};
    end else if (rnd_e >= 10'sd255) begin
      y_n   = FP_PINF | {s2_sign, 31'd0};
      ovf_n = 1'b1;
    end
  end

  // ---------------- Control and output register (reset)
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      y         <= '0;
      out_tag   <= '0;
      ovf       <= 1'b0;
      nan       <= 1'b0;
    end else if (advance) begin
      v1        <= in_valid;
      v2        <= v1;
      out_valid <= v2;
      y         <= y_n;
      out_tag   <= s2_tag;
      ovf       <= ovf_n;
      nan       <= nan_n;
    end
  end

  // ---------------- Stage data registers (don't-care while invalid)
  always_ff @(posedge sys_clk) begin
    if (advance) begin
      s1_sum     <= sum;
      s1_exp     <= big_e;
      s1_sign    <= big_s;
      s1_zsign   <= a.sign & sb;
      s1_sp      <= sp_n;
      s1_sp_sign <= sp_sign_n;
      s1_tag     <= in_tag;
      s2_man     <= norm_m;
      s2_exp     <= norm_e;
      s2_zero    <= (s1_sum == '0);
      s2_sign    <= s1_sign;
      s2_zsign   <= s1_zsign;
      s2_sp      <= s1_sp;
      s2_sp_sign <= s1_sp_sign;
      s2_tag     <= s1_tag;
    end
  end

endmodule
